// File: rtl/pipeline_mem_wbuf.sv
// Store write buffer between the memory stage and the data bus.
// It holds byte-masked stores in a circular FIFO, can combine stores into the youngest entry, and flags loads that hit a pending word.
module pipeline_mem_wbuf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MERGE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [DATA_W/8-1:0]      st_mask,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hazard,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W/8-1:0]      bus_mask,
  output logic [DATA_W-1:0]        bus_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned OFS_W  = $clog2(MASK_W);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WA_W   = ADDR_W - OFS_W;

  logic [WA_W-1:0]   word_q [DEPTH];
  logic [MASK_W-1:0] mask_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, young;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, deq, merge, push;
  logic [WA_W-1:0]  st_word, ld_word;
  logic             unused_ofs;

  assign st_word    = st_addr[ADDR_W-1:OFS_W];
  assign ld_word    = ld_addr[ADDR_W-1:OFS_W];
  assign unused_ofs = ^{st_addr[OFS_W-1:0], ld_addr[OFS_W-1:0]};

  assign st_ready  = (count_q != CNT_W'(DEPTH));
  assign bus_valid = (count_q != '0);
  assign accept    = st_valid && st_ready;
  assign deq       = bus_valid && bus_ready;
  assign young     = tail_q - PTR_W'(1);

  // With two or more entries the youngest is never the head, so the head stays stable while it is presented.
  assign merge = (MERGE != 0) && accept && (st_mask != '0) &&
                 (count_q >= CNT_W'(2)) && (young != head_q) &&
                 (word_q[young] == st_word);
  assign push  = accept && (st_mask != '0) && !merge;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (deq)  head_d = head_q + PTR_W'(1);
    case ({push, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) begin
        word_q[tail_q] <= st_word;
        mask_q[tail_q] <= st_mask;
        data_q[tail_q] <= st_data;
      end else if (merge) begin
        mask_q[young] <= mask_q[young] | st_mask;
        for (int unsigned b = 0; b < MASK_W; b++) begin
          if (st_mask[b]) data_q[young][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) && (word_q[i] == ld_word))
        ld_hazard = 1'b1;
    end
  end

  assign bus_addr = {word_q[head_q], {OFS_W{1'b0}}};
  assign bus_mask = mask_q[head_q];
  assign bus_data = data_q[head_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: tb/tb_pipeline_mem_wbuf.sv
// Bench for pipeline_mem_wbuf: directed steps then random traffic, checked against a queue-based model of the buffer.
module tb_pipeline_mem_wbuf;
  localparam int DEPTH = 4;
  localparam int MERGE = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [3:0]  st_mask;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        ld_hazard, bus_valid, bus_ready;
  logic [31:0] bus_addr, bus_data;
  logic [3:0]  bus_mask;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] word;
    logic [3:0]  mask;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];

  pipeline_mem_wbuf #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .MERGE(MERGE)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_mask(st_mask),
    .st_addr(st_addr), .st_data(st_data),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_mask(bus_mask), .bus_data(bus_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic v, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_mask  = m;
    st_addr  = a;
    st_data  = d;
  endtask

  // Compare current outputs to the model, advance the model by one clock, then step to the next falling edge.
  task automatic tick();
    bit   rdy, acc, dq, hz;
    ent_t e;
    int   n;
    #1;
    n   = q.size();
    rdy = (n < DEPTH);
    acc = st_valid && rdy;
    dq  = (n > 0) && bus_ready;
    hz  = 1'b0;
    foreach (q[i]) if (q[i].word == ld_addr[31:2]) hz = 1'b1;
    chk("st_ready", {31'd0, st_ready}, {31'd0, rdy});
    chk("bus_valid", {31'd0, bus_valid}, {31'd0, (n > 0)});
    chk("count", {29'd0, count}, n);
    chk("empty", {31'd0, empty}, {31'd0, (n == 0)});
    chk("ld_hazard", {31'd0, ld_hazard}, {31'd0, hz});
    if (n > 0) begin
      chk("bus_addr", bus_addr, {q[0].word, 2'b00});
      chk("bus_mask", {28'd0, bus_mask}, {28'd0, q[0].mask});
      chk("bus_data", bus_data, q[0].data);
    end
    if (rst) begin
      q.delete();
    end else begin
      if (acc && st_mask != 4'd0) begin
        if (MERGE != 0 && n >= 2 && q[n-1].word == st_addr[31:2]) begin
          e = q[n-1];
          for (int b = 0; b < 4; b++) if (st_mask[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
          e.mask = e.mask | st_mask;
          q[n-1] = e;
        end else begin
          e.word = st_addr[31:2];
          e.mask = st_mask;
          e.data = st_data;
          q.push_back(e);
        end
      end
      if (dq) void'(q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_ready = 1'b0;
    ld_addr = 32'd0;
    st(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("reset_st_ready", {31'd0, st_ready}, 32'd1);
    chk("reset_ld_hazard", {31'd0, ld_hazard}, 32'd0);

    // First store appears on the bus the following cycle
    st(1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    tick();
    st(1'b0, 4'h0, 32'h0, 32'h0);
    chk("first_bus_valid", {31'd0, bus_valid}, 32'd1);
    chk("first_bus_addr", bus_addr, 32'h100);
    chk("first_bus_mask", {28'd0, bus_mask}, 32'hF);
    chk("first_count", {29'd0, count}, 32'd1);

    // Fill to DEPTH, refuse a fifth, then drain in order
    for (int i = 1; i < 4; i++) begin
      st(1'b1, 4'hF, 32'h100 + 32'(i) * 32'h10, 32'h1111_0000 + 32'(i));
      tick();
    end
    st(1'b1, 4'hF, 32'h140, 32'h55555555);
    #1;
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_st_ready", {31'd0, st_ready}, 32'd0);
    tick();
    st(1'b0, 4'h0, 32'h0, 32'h0);
    bus_ready = 1'b1;
    repeat (5) tick();

    // Write-combining into the youngest entry
    bus_ready = 1'b0;
    st(1'b1, 4'b0001, 32'h200, 32'h000000AA); tick();
    st(1'b1, 4'b0100, 32'h300, 32'h00EE0000); tick();
    st(1'b1, 4'b1100, 32'h302, 32'hBBBB0000); tick();
    chk("merge1_count", {29'd0, count}, 32'd2);
    st(1'b1, 4'b0010, 32'h301, 32'h0000CC00); tick();
    chk("merge2_count", {29'd0, count}, 32'd2);
    st(1'b0, 4'h0, 32'h0, 32'h0);
    bus_ready = 1'b1;
    tick();
    chk("merged_mask", {28'd0, bus_mask}, 32'hE);
    chk("merged_data", bus_data, 32'hBBBBCC00);
    tick();

    // Load hazard against a pending store
    bus_ready = 1'b0;
    st(1'b1, 4'hF, 32'h400, 32'h12345678); tick();
    st(1'b0, 4'h0, 32'h0, 32'h0);
    ld_addr = 32'h403; tick();
    ld_addr = 32'h404; tick();
    bus_ready = 1'b1; tick();
    ld_addr = 32'h403;
    #1;
    chk("hazard_after_drain", {31'd0, ld_hazard}, 32'd0);
    tick();

    // Zero-mask store is consumed without effect
    st(1'b1, 4'h0, 32'h500, 32'hFFFFFFFF); tick();
    chk("zero_mask_count", {29'd0, count}, 32'd0);
    chk("zero_mask_bus_valid", {31'd0, bus_valid}, 32'd0);

    // Full buffer with simultaneous dequeue and store
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(1'b1, 4'hF, 32'h600 + 32'(i) * 32'h4, 32'hA0 + 32'(i));
      tick();
    end
    bus_ready = 1'b1;
    st(1'b1, 4'hF, 32'h700, 32'hCAFE0000);
    tick();
    chk("full_deq_count", {29'd0, count}, 32'd3);
    st(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (4) tick();

    // Reset with entries pending
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st(1'b1, 4'hF, 32'h800 + 32'(i) * 32'h4, 32'hB0 + 32'(i));
      tick();
    end
    st(1'b0, 4'h0, 32'h0, 32'h0);
    bus_ready = 1'b1;
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_bus_valid", {31'd0, bus_valid}, 32'd0);

    // Random traffic over a small address pool to provoke merges and hazards
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      bus_ready = ($urandom_range(0, 2) != 0);
      st($urandom_range(0, 3) != 0,
         ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
         32'h1000 + 32'($urandom_range(0, 4)) * 32'h4 + 32'($urandom_range(0, 3)),
         $urandom);
      ld_addr = 32'h1000 + 32'($urandom_range(0, 5)) * 32'h4 + 32'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    st(1'b0, 4'h0, 32'h0, 32'h0);
    bus_ready = 1'b1;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
